i2c_bus_sampler: RTL and testbench
==================================

# i2c_bus_sampler

Front-end conditioner for raw I2C pins. It synchronises and deglitches `sda`/`scl`, then emits clean filtered lines and single-cycle bus events: edges, START, STOP, bit strobes and optionally assembled bytes. It sits directly upstream of the I2C waveform-matching FSM, which consumes `sda_f`/`scl_f` in place of the raw pins.

## Interface
- `FILT_LEN`, default 4: consecutive stable cycles required before a filtered line changes; legal range 1..15.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `sda` input 1: raw SDA pin, asynchronous to `clk`.
- `scl` input 1: raw SCL pin, asynchronous to `clk`.
- `sda_f` output 1: filtered SDA.
- `scl_f` output 1: filtered SCL.
- `scl_rise` output 1: one-cycle pulse on a filtered SCL 0→1 transition.
- `scl_fall` output 1: one-cycle pulse on a filtered SCL 1→0 transition.
- `start_det` output 1: one-cycle pulse on START or repeated START.
- `stop_det` output 1: one-cycle pulse on STOP.
- `bus_busy` output 1: high between START and STOP.
- `bit_valid` output 1: one-cycle pulse with each data/ack bit while busy.
- `bit_data` output 1: sampled SDA; valid only with `bit_valid`.
- `byte_valid` output 1: one-cycle pulse after the 8th bit.
- `byte_data` output 8: assembled byte, MSB first; held until the next `byte_valid`.
- `ack_valid` output 1: one-cycle pulse on the 9th bit.
- `ack_n` output 1: 9th-bit SDA value (0 = ACK); held until the next `ack_valid`.

## Operation
- **Synchroniser.** Two flops per line; both flops reset to 1.
- **Glitch filter**, one per line:
  - Tracks the synchronised value `s` and the filtered output `f`, with a counter `cnt`.
  - If `s == f`: `cnt <= 0`.
  - Else if `cnt == FILT_LEN-1`: `f <= s` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Pulses shorter than `FILT_LEN` cycles are rejected.
- **Event detection.** Compares the current filtered values against a one-cycle-delayed copy (`sda_d`, `scl_d`).
  - START: `sda` falls while `scl_f` and `scl_d` are both 1.
  - STOP: `sda` rises while `scl_f` and `scl_d` are both 1.
  - If SDA and SCL change in the same cycle, only the SCL edge pulse is generated; neither START nor STOP.
- **Bus state machine**, states IDLE and BUSY:
  - IDLE → BUSY on START.
  - BUSY → BUSY on START (repeated START): bit counter cleared.
  - BUSY → IDLE on STOP: bit counter cleared.
  - `bus_busy` = (state == BUSY).
- **Bit strobe.** On `scl_rise` in BUSY: `bit_valid` = 1 and `bit_data` = `sda_f`. No bit strobes in IDLE.
- **Bit counter** (0..8):
  - Increments on each bit strobe.
  - Bits 0..7 shift into `byte_data` MSB first.
  - At count 7: `byte_valid` pulses.
  - At count 8: `ack_valid` pulses, `ack_n` is latched, and the counter wraps to 0.
- **Reset values.**
  - `sda_f`, `scl_f` = 1.
  - All pulses, `bus_busy`, `byte_data`, `ack_n`, counters = 0.
  - State = IDLE.
- **Reset mid-byte.** Partial byte is discarded; no `byte_valid`.

## Timing
- Pin change → `sda_f`/`scl_f` change: 2 + `FILT_LEN` cycles (stable input assumed).
- Filtered change → any event pulse: 1 cycle; all event outputs are registered.
- `byte_valid`/`byte_data` are asserted in the same cycle as the 8th `bit_valid`; `byte_data` includes that bit.
- START/STOP pulses are never coincident with `bit_valid`.
- STOP during a byte: `stop_det` fires and the partial byte is dropped silently.

## Configuration
- `I2C_SAMPLER_BYTE_EN` defined:
  - Bit counter, shift register, `byte_valid`/`byte_data`/`ack_valid`/`ack_n` logic present as described.
- `I2C_SAMPLER_BYTE_EN` undefined:
  - That logic is absent; `byte_valid`, `ack_valid`, `ack_n` and `byte_data` are tied to 0.
  - Filtered lines, edges, START/STOP, `bus_busy` and bit strobes are unaffected.

## Structure
- Shared package `i2c_pkg`:
  - Bus-state enum (`I2C_IDLE`, `I2C_BUSY`).
  - `I2C_FILT_CNT_W` = 4.
  - `I2C_BITS_PER_FRAME` = 9.
- Sub-module `i2c_glitch_filter` (sync + stable-count filter, one line); instantiated twice with shared `FILT_LEN`.

## Test plan
- Glitch rejection: with `FILT_LEN`=4, drive a 3-cycle low pulse on idle SDA → `sda_f` stays 1, no events. A 4-cycle pulse → `sda_f` goes to 0 exactly 6 cycles after the pin edge.
- START then STOP: SDA low while SCL high, then SDA high → `start_det` pulse, `bus_busy` = 1, then `stop_det` pulse, `bus_busy` = 0; `bit_valid` never asserted.
- Byte 0xA5 + ACK: START, 9 SCL clocks carrying 1,0,1,0,0,1,0,1,0 → 9 `bit_valid` pulses, `byte_valid` with `byte_data`=0xA5 on the 8th, `ack_valid` with `ack_n`=0 on the 9th.
- Repeated START after 3 bits, then byte 0x3C → no `byte_valid` for the partial byte; next `byte_valid` carries 0x3C.
- `reset` asserted after 5 bits → all outputs return to reset values immediately (asynchronous). After release, a full byte 0xFF is assembled correctly.
- SDA and SCL released high in the same cycle while BUSY → `scl_rise` only, no `stop_det`, `bus_busy` stays 1.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C bus sampler.
// Holds the bus-state enum and the filter and frame sizing.
package i2c_pkg;

  typedef enum logic {
    I2C_IDLE = 1'b0,
    I2C_BUSY = 1'b1
  } i2c_state_e;

  localparam int I2C_FILT_CNT_W     = 4;
  localparam int I2C_BITS_PER_FRAME = 9;

endpackage

// File: rtl/i2c_bus_sampler_if.sv
// i2c_bus_sampler_if: raw pins in, filtered lines and events out.
// master drives the pins, slave is the sampler itself.
interface i2c_bus_sampler_if;
  logic       sda;
  logic       scl;
  logic       sda_f;
  logic       scl_f;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       bus_busy;
  logic       bit_valid;
  logic       bit_data;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       ack_valid;
  logic       ack_n;

  modport master (
    output sda, scl,
    input  sda_f, scl_f, scl_rise, scl_fall,
    input  start_det, stop_det, bus_busy,
    input  bit_valid, bit_data,
    input  byte_valid, byte_data, ack_valid, ack_n
  );

  modport slave (
    input  sda, scl,
    output sda_f, scl_f, scl_rise, scl_fall,
    output start_det, stop_det, bus_busy,
    output bit_valid, bit_data,
    output byte_valid, byte_data, ack_valid, ack_n
  );
endinterface

// File: rtl/i2c_glitch_filter.sv
// i2c_glitch_filter: 2-flop synchroniser plus stable-count filter.
// The output follows the pin only after FILT_LEN stable cycles.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic f_o
);
  localparam int W = I2C_FILT_CNT_W;
  localparam logic [W-1:0] LAST = W'(FILT_LEN - 1);

  logic         s1_q, s2_q;
  logic         f_q, f_d;
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    f_d   = f_q;
    cnt_d = cnt_q;
    if (s2_q == f_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      f_d   = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      f_q   <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q  <= pin_i;
      s2_q  <= s1_q;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign f_o = f_q;
endmodule

// File: rtl/i2c_bus_sampler.sv
// i2c_bus_sampler: deglitched SDA/SCL, edges, START/STOP, bit strobes.
// Byte and ACK assembly present only with I2C_SAMPLER_BYTE_EN defined.
module i2c_bus_sampler
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input logic              clk,
  input logic              reset,
  i2c_bus_sampler_if.slave bus
);
  logic       sda_f, scl_f;
  logic       sda_d_q, scl_d_q;
  logic       rise_c, fall_c, start_c, stop_c, bit_c;
  logic       rise_q, fall_q, start_q, stop_q;
  logic       bitv_q, bitd_q, bitd_d;
  i2c_state_e state_q, state_d;

  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk  (clk),
    .reset(reset),
    .pin_i(bus.sda),
    .f_o  (sda_f)
  );

  i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk  (clk),
    .reset(reset),
    .pin_i(bus.scl),
    .f_o  (scl_f)
  );

  // SDA edges count as START/STOP only while SCL is steadily high
  always_comb begin
    rise_c  = scl_f & ~scl_d_q;
    fall_c  = ~scl_f & scl_d_q;
    start_c = scl_f & scl_d_q & ~sda_f & sda_d_q;
    stop_c  = scl_f & scl_d_q & sda_f & ~sda_d_q;
    bit_c   = rise_c & (state_q == I2C_BUSY);
    bitd_d  = bit_c ? sda_f : bitd_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      I2C_IDLE: if (start_c) state_d = I2C_BUSY;
      I2C_BUSY: if (stop_c) state_d = I2C_IDLE;
      default:  state_d = I2C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sda_d_q <= 1'b1;
      scl_d_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      bitv_q  <= 1'b0;
      bitd_q  <= 1'b0;
      state_q <= I2C_IDLE;
    end else begin
      sda_d_q <= sda_f;
      scl_d_q <= scl_f;
      rise_q  <= rise_c;
      fall_q  <= fall_c;
      start_q <= start_c;
      stop_q  <= stop_c;
      bitv_q  <= bit_c;
      bitd_q  <= bitd_d;
      state_q <= state_d;
    end
  end

  assign bus.sda_f     = sda_f;
  assign bus.scl_f     = scl_f;
  assign bus.scl_rise  = rise_q;
  assign bus.scl_fall  = fall_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;
  assign bus.bus_busy  = (state_q == I2C_BUSY);
  assign bus.bit_valid = bitv_q;
  assign bus.bit_data  = bitd_q;

`ifdef I2C_SAMPLER_BYTE_EN
  localparam logic [3:0] LAST = 4'(I2C_BITS_PER_FRAME - 1);

  logic [3:0] bcnt_q, bcnt_d;
  logic [6:0] sr_q, sr_d;
  logic [7:0] byte_q, byte_d;
  logic       bytev_q, bytev_d;
  logic       ackv_q, ackv_d;
  logic       ackn_q, ackn_d;

  // bit index LAST is the ACK slot; the byte completes one bit earlier
  always_comb begin
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    byte_d  = byte_q;
    bytev_d = 1'b0;
    ackv_d  = 1'b0;
    ackn_d  = ackn_q;
    if (start_c | stop_c) begin
      bcnt_d = '0;
    end else if (bit_c) begin
      if (bcnt_q == LAST) begin
        bcnt_d = '0;
        ackv_d = 1'b1;
        ackn_d = sda_f;
      end else begin
        bcnt_d = bcnt_q + 4'd1;
        sr_d   = {sr_q[5:0], sda_f};
        if (bcnt_q == LAST - 4'd1) begin
          bytev_d = 1'b1;
          byte_d  = {sr_q, sda_f};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q  <= '0;
      sr_q    <= '0;
      byte_q  <= '0;
      bytev_q <= 1'b0;
      ackv_q  <= 1'b0;
      ackn_q  <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      byte_q  <= byte_d;
      bytev_q <= bytev_d;
      ackv_q  <= ackv_d;
      ackn_q  <= ackn_d;
    end
  end

  assign bus.byte_valid = bytev_q;
  assign bus.byte_data  = byte_q;
  assign bus.ack_valid  = ackv_q;
  assign bus.ack_n      = ackn_q;
`else
  assign bus.byte_valid = 1'b0;
  assign bus.byte_data  = 8'h00;
  assign bus.ack_valid  = 1'b0;
  assign bus.ack_n      = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_bus_sampler.sv
// tb_i2c_bus_sampler: directed and random pin stimulus for the sampler.
// A cycle-level behavioural model is compared against every output.
module tb_i2c_bus_sampler;
  localparam int FL = 4;
  localparam int H  = FL + 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  i2c_bus_sampler_if bus ();

  i2c_bus_sampler #(.FILT_LEN(FL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model state
  bit       pq_sda[$];
  bit       pq_scl[$];
  bit       m_sda1, m_sda2, m_scl1, m_scl2, m_busy;
  int       m_nbits;
  bit [7:0] m_acc, m_byte;
  bit       m_ack;
  bit       e_rise, e_fall, e_start, e_stop;
  bit       e_bitv, e_bitd, e_bytev, e_ackv;

  // observed event counters
  int       n_start, n_stop, n_rise, n_bit, n_byte, n_ack;
  bit [7:0] last_byte;
  bit       last_ack;
  bit       saw_sda_lo;

  task automatic chk1(string nm, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chki(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    pq_sda.delete();
    pq_scl.delete();
    for (int i = 0; i < FL + 2; i++) begin
      pq_sda.push_back(1'b1);
      pq_scl.push_back(1'b1);
    end
    m_sda1 = 1; m_sda2 = 1; m_scl1 = 1; m_scl2 = 1;
    m_busy = 0; m_nbits = 0; m_acc = 0; m_byte = 0; m_ack = 0;
    e_rise = 0; e_fall = 0; e_start = 0; e_stop = 0;
    e_bitv = 0; e_bitd = 0; e_bytev = 0; e_ackv = 0;
  endtask

  // q[0] is the pin sampled at this edge; the filter sees q[2..]
  function automatic bit filt(input bit q[$], input bit f);
    bit flip = 1'b1;
    for (int k = 2; k < FL + 2; k++)
      if (q[k] == f) flip = 1'b0;
    return flip ? ~f : f;
  endfunction

  task automatic model_step();
    bit ns, nc;
    pq_sda.push_front(bus.sda);
    pq_scl.push_front(bus.scl);
    void'(pq_sda.pop_back());
    void'(pq_scl.pop_back());
    ns = filt(pq_sda, m_sda1);
    nc = filt(pq_scl, m_scl1);
    e_rise  = m_scl1 && !m_scl2;
    e_fall  = !m_scl1 && m_scl2;
    e_start = m_scl1 && m_scl2 && !m_sda1 && m_sda2;
    e_stop  = m_scl1 && m_scl2 && m_sda1 && !m_sda2;
    e_bitv  = e_rise && m_busy;
    e_bitd  = m_sda1;
    e_bytev = 0;
    e_ackv  = 0;
    if (e_start) begin m_busy = 1; m_nbits = 0; end
    if (e_stop)  begin m_busy = 0; m_nbits = 0; end
    if (e_bitv) begin
      m_nbits++;
      if (m_nbits <= 8) m_acc = {m_acc[6:0], e_bitd};
      if (m_nbits == 8) begin e_bytev = 1; m_byte = m_acc; end
      if (m_nbits == 9) begin e_ackv = 1; m_ack = e_bitd; m_nbits = 0; end
    end
    m_sda2 = m_sda1; m_sda1 = ns;
    m_scl2 = m_scl1; m_scl1 = nc;
  endtask

  task automatic check_all();
    chk1("sda_f", bus.sda_f, m_sda1);
    chk1("scl_f", bus.scl_f, m_scl1);
    chk1("scl_rise", bus.scl_rise, e_rise);
    chk1("scl_fall", bus.scl_fall, e_fall);
    chk1("start_det", bus.start_det, e_start);
    chk1("stop_det", bus.stop_det, e_stop);
    chk1("bus_busy", bus.bus_busy, m_busy);
    chk1("bit_valid", bus.bit_valid, e_bitv);
    if (e_bitv) chk1("bit_data", bus.bit_data, e_bitd);
`ifdef I2C_SAMPLER_BYTE_EN
    chk1("byte_valid", bus.byte_valid, e_bytev);
    chk8("byte_data", bus.byte_data, m_byte);
    chk1("ack_valid", bus.ack_valid, e_ackv);
    chk1("ack_n", bus.ack_n, m_ack);
`else
    chk1("byte_valid", bus.byte_valid, 1'b0);
    chk8("byte_data", bus.byte_data, 8'h00);
    chk1("ack_valid", bus.ack_valid, 1'b0);
    chk1("ack_n", bus.ack_n, 1'b0);
`endif
    n_start += int'(bus.start_det);
    n_stop  += int'(bus.stop_det);
    n_rise  += int'(bus.scl_rise);
    n_bit   += int'(bus.bit_valid);
    if (!bus.sda_f) saw_sda_lo = 1'b1;
    if (bus.byte_valid) begin n_byte++; last_byte = bus.byte_data; end
    if (bus.ack_valid) begin n_ack++; last_ack = bus.ack_n; end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(bit d, bit c, int n);
    bus.sda = d;
    bus.scl = c;
    cyc(n);
  endtask

  task automatic i2c_start();
    drive(1, 1, H);
    drive(0, 1, H);
    drive(0, 0, H);
  endtask

  task automatic i2c_stop();
    drive(0, 0, H);
    drive(0, 1, H);
    drive(1, 1, H);
  endtask

  task automatic i2c_bit(bit b);
    drive(b, 0, H);
    drive(b, 1, H);
    drive(b, 0, H);
  endtask

  task automatic send_byte(bit [7:0] v, bit a);
    for (int i = 7; i >= 0; i--) i2c_bit(v[i]);
    i2c_bit(a);
  endtask

  task automatic stimulus();
    int b0, b1, b2, lat, nb;
    bit [7:0] rb;
    bus.sda = 1'b1;
    bus.scl = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    #2;
    chk1("rst_sda_f", bus.sda_f, 1'b1);
    chk1("rst_scl_f", bus.scl_f, 1'b1);
    chk1("rst_busy", bus.bus_busy, 1'b0);
    chk8("rst_byte", bus.byte_data, 8'h00);
    cyc(3);
    reset = 1'b1;
    cyc(5);

    // glitch rejection
    saw_sda_lo = 0; b0 = n_start; b1 = n_stop;
    drive(0, 1, 3);
    drive(1, 1, 12);
    chk1("glitch3_sda_lo", saw_sda_lo, 1'b0);
    chki("glitch3_start", n_start - b0, 0);
    chki("glitch3_stop", n_stop - b1, 0);
    lat = 0;
    bus.sda = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 4) bus.sda = 1'b1;
      if (!bus.sda_f && lat == 0) lat = i;
    end
    chki("filt_latency", lat, 2 + FL);
    cyc(H);

    // START then STOP
    b0 = n_start; b1 = n_stop; b2 = n_bit;
    drive(0, 1, H);
    chk1("ss_busy1", bus.bus_busy, 1'b1);
    drive(1, 1, H);
    chk1("ss_busy0", bus.bus_busy, 1'b0);
    chki("ss_start", n_start - b0, 1);
    chki("ss_stop", n_stop - b1, 1);
    chki("ss_bits", n_bit - b2, 0);

    // byte 0xA5 with ACK
    b0 = n_bit; b1 = n_byte; b2 = n_ack;
    i2c_start();
    send_byte(8'hA5, 1'b0);
    chki("a5_bits", n_bit - b0, 9);
`ifdef I2C_SAMPLER_BYTE_EN
    chki("a5_nbyte", n_byte - b1, 1);
    chk8("a5_byte", last_byte, 8'hA5);
    chki("a5_nack", n_ack - b2, 1);
    chk1("a5_ack", last_ack, 1'b0);
`endif
    i2c_stop();

    // repeated START after a partial byte
    b0 = n_start; b1 = n_byte;
    i2c_start();
    i2c_bit(1); i2c_bit(0); i2c_bit(1);
    drive(1, 0, H);
    drive(1, 1, H);
    drive(0, 1, H);
    drive(0, 0, H);
    send_byte(8'h3C, 1'b1);
    i2c_stop();
    chki("rs_start", n_start - b0, 2);
`ifdef I2C_SAMPLER_BYTE_EN
    chki("rs_nbyte", n_byte - b1, 1);
    chk8("rs_byte", last_byte, 8'h3C);
`endif

    // asynchronous reset mid-byte
    i2c_start();
    for (int i = 0; i < 5; i++) i2c_bit(1);
    chk1("pre_rst_busy", bus.bus_busy, 1'b1);
    reset = 1'b0;
    model_reset();
    #1;
    chk1("arst_busy", bus.bus_busy, 1'b0);
    chk1("arst_sda_f", bus.sda_f, 1'b1);
    chk1("arst_scl_f", bus.scl_f, 1'b1);
    chk1("arst_bitv", bus.bit_valid, 1'b0);
    chk8("arst_byte", bus.byte_data, 8'h00);
    chk1("arst_ack_n", bus.ack_n, 1'b0);
    drive(1, 1, 3);
    reset = 1'b1;
    cyc(H);
    b1 = n_byte;
    i2c_start();
    send_byte(8'hFF, 1'b0);
    i2c_stop();
`ifdef I2C_SAMPLER_BYTE_EN
    chki("ff_nbyte", n_byte - b1, 1);
    chk8("ff_byte", last_byte, 8'hFF);
`endif

    // SDA and SCL released together while busy
    i2c_start();
    b0 = n_rise; b1 = n_stop;
    drive(1, 1, H);
    chki("sim_rise", n_rise - b0, 1);
    chki("sim_stop", n_stop - b1, 0);
    chk1("sim_busy", bus.bus_busy, 1'b1);
    drive(1, 0, H);
    i2c_stop();

    // random traffic
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int j = 0; j < 40; j++)
          drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(1, 2 * FL));
        drive(1, 1, H);
      end else begin
        i2c_start();
        nb = $urandom_range(1, 3);
        for (int k = 0; k < nb; k++) begin
          rb = 8'($urandom);
          drive(~rb[7], 0, $urandom_range(1, FL - 1));
          send_byte(rb, 1'($urandom_range(0, 1)));
        end
        i2c_stop();
      end
    end
    cyc(20);
  endtask

  initial begin
    n_start = 0; n_stop = 0; n_rise = 0; n_bit = 0;
    n_byte = 0; n_ack = 0; last_byte = 0; last_ack = 0;
    saw_sda_lo = 0;
    fork
      forever begin
        @(posedge clk);
        if (reset) begin
          model_step();
          #1;
          check_all();
        end
      end
      stimulus();
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
